// File: rtl/mash_pkg.sv
// Shared constants and helpers for the MASH noise-cancellation network.
package mash_pkg;

    localparam int MAX_ORDER = 4;

    function automatic int ncl_width(input int order);
        return order + 1;
    endfunction

    // Map the runtime order request onto 1..max_order.
    function automatic logic [2:0] clamp_order(input logic [2:0] sel, input int max_order);
        if (sel == 3'd0)
            return 3'd1;
        if (int'(sel) > max_order)
            return 3'(max_order);
        return sel;
    endfunction

endpackage

// File: rtl/mash_diff_stage.sv
// One differentiating stage: t = c + t_next[n-1] - t_next[n].
// Combinational output, history updates on step; no backpressure (flush clears history).
module mash_diff_stage #(
    parameter int OW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 c,
    input  logic signed [OW-1:0] t_next,
    input  logic                 step,
    input  logic                 flush,
    output logic signed [OW-1:0] t
);

    logic signed [OW-1:0] p;

    assign t = $signed({{(OW-1){1'b0}}, c}) + p - t_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            p <= '0;
        else if (flush)
            p <= '0;
        else if (step)
            p <= t_next;
    end

endmodule

// File: rtl/mash_ncl_n.sv
// MASH noise-cancellation network with runtime order select, flush and settled flag.
// Latency 1 cycle in_valid -> out_valid; no backpressure, idle cycles hold state.
module mash_ncl_n
    import mash_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int OW    = ncl_width(ORDER)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [ORDER-1:0]     carry,
    input  logic [2:0]           order_sel,
    input  logic                 clear,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_f,
    output logic                 settled
);

    localparam logic [2:0] ORD3 = 3'(ORDER);
    localparam logic [3:0] ORD4 = 4'(ORDER);

    logic [2:0]           n_eff;
    logic [2:0]           order_q;
    logic [2:0]           cnt;
    logic [3:0]           cnt_inc;
    logic                 flush;
    logic                 step;
    logic [ORDER-1:0]     c_m;
    logic signed [OW-1:0] t [1:ORDER];

    assign n_eff   = clamp_order(order_sel, ORDER);
    assign flush   = clear || (n_eff != order_q);
    assign step    = in_valid && !flush;
    assign cnt_inc = {1'b0, cnt} + 4'd1;

    for (genvar k = 0; k < ORDER; k++) begin : g_mask
        assign c_m[k] = carry[k] && (k < int'(n_eff));
    end

    // Masked upper carries keep their stages at zero, so the chain always spans ORDER.
    assign t[ORDER] = $signed({{(OW-1){1'b0}}, c_m[ORDER-1]});

    for (genvar k = 1; k < ORDER; k++) begin : g_stage
        mash_diff_stage #(.OW(OW)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .c      (c_m[k-1]),
            .t_next (t[k+1]),
            .step   (step),
            .flush  (flush),
            .t      (t[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_f     <= '0;
            out_valid <= 1'b0;
            settled   <= 1'b0;
            cnt       <= '0;
            order_q   <= ORD3;
        end else if (flush) begin
            out_f     <= '0;
            out_valid <= 1'b0;
            settled   <= 1'b0;
            cnt       <= '0;
            order_q   <= n_eff;
        end else if (step) begin
            out_f     <= t[1];
            out_valid <= 1'b1;
            settled   <= (cnt_inc >= {1'b0, n_eff});
            cnt       <= (cnt_inc > ORD4) ? ORD3 : cnt_inc[2:0];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mash_ncl_n.sv
// Directed and model-checked bench for mash_ncl_n at ORDER=3 and ORDER=4.
module tb_mash_ncl_n;

    logic clk = 1'b0;
    logic rst_n;

    logic              in_valid3, clear3, out_valid3, settled3;
    logic [2:0]        carry3, order_sel3;
    logic signed [3:0] out_f3;

    logic              in_valid4, clear4, out_valid4, settled4;
    logic [3:0]        carry4;
    logic [2:0]        order_sel4;
    logic signed [4:0] out_f4;

    int checks = 0;
    int errors = 0;
    int h [0:1][0:3][1:4];

    always #5 clk = ~clk;

    mash_ncl_n #(.ORDER(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .carry(carry3),
        .order_sel(order_sel3), .clear(clear3), .out_valid(out_valid3),
        .out_f(out_f3), .settled(settled3)
    );

    mash_ncl_n #(.ORDER(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .carry(carry4),
        .order_sel(order_sel4), .clear(clear4), .out_valid(out_valid4),
        .out_f(out_f4), .settled(settled4)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int binom(input int a, input int b);
        int r = 1;
        for (int i = 0; i < b; i++)
            r = r * (a - i) / (i + 1);
        return r;
    endfunction

    task automatic m_clear(input int d);
        for (int m = 0; m < 4; m++)
            for (int k = 1; k <= 4; k++)
                h[d][m][k] = 0;
    endtask

    // Expanded form: sum_k sum_m C(k-1,m) (-1)^(k-1-m) c_k[n-m].
    task automatic m_step(input int d, input int n, input logic [3:0] c, output int y);
        for (int m = 3; m > 0; m--)
            for (int k = 1; k <= 4; k++)
                h[d][m][k] = h[d][m-1][k];
        for (int k = 1; k <= 4; k++)
            h[d][0][k] = (k <= n) ? int'(c[k-1]) : 0;
        y = 0;
        for (int k = 1; k <= n; k++)
            for (int m = 0; m < k; m++)
                y += binom(k - 1, m) * ((((k - 1 - m) % 2) == 1) ? -1 : 1) * h[d][m][k];
    endtask

    initial begin
        int y, last, gap;
        logic [2:0] pat3 [8];
        int         exp3 [8];
        logic [3:0] pat4 [5];
        int         exp4 [5];

        pat3 = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
        exp3 = '{-1, 1, 0, 0, 1, -2, 1, 0};
        pat4 = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        exp4 = '{-1, 3, -3, 1, 0};

        rst_n = 1'b0;
        in_valid3 = 1'b0; clear3 = 1'b0; carry3 = '0; order_sel3 = 3'd3;
        in_valid4 = 1'b0; clear4 = 1'b0; carry4 = '0; order_sel4 = 3'd4;
        m_clear(0);
        m_clear(1);
        repeat (2) tick();
        chk("rst_f3", out_f3, 0);
        chk("rst_v3", out_valid3, 0);
        chk("rst_f4", out_f4, 0);
        chk("rst_s4", settled4, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_f", out_f3, 0);
            chk("idle_v", out_valid3, 0);
            chk("idle_s", settled3, 0);
        end

        // Constant c1: output is c1 itself, settled from the third output.
        carry3 = 3'b001;
        in_valid3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            m_step(0, 3, {1'b0, carry3}, y);
            chk("c1_v", out_valid3, 1);
            chk("c1_f", out_f3, 1);
            chk("c1_s", settled3, (i >= 2) ? 1 : 0);
        end

        for (int i = 0; i < 8; i++) begin
            carry3 = pat3[i];
            tick();
            m_step(0, 3, {1'b0, carry3}, y);
            chk("pulse3", out_f3, exp3[i]);
        end
        in_valid3 = 1'b0;

        in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            carry4 = pat4[i];
            tick();
            m_step(1, 4, carry4, y);
            chk("pulse4", out_f4, exp4[i]);
        end
        for (int i = 0; i < 2000; i++) begin
            carry4 = 4'($urandom_range(0, 15));
            tick();
            m_step(1, 4, carry4, y);
            chk("rnd4_f", out_f4, y);
            chk("rnd4_rng", (out_f4 >= -7 && out_f4 <= 8) ? 1 : 0, 1);
        end

        last = out_f3;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid3 = 1'b0;
                carry3 = 3'($urandom_range(0, 7));
                gap = $urandom_range(1, 5);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap_v", out_valid3, 0);
                    chk("gap_f", out_f3, last);
                end
            end
            in_valid3 = 1'b1;
            carry3 = 3'($urandom_range(0, 7));
            tick();
            m_step(0, 3, {1'b0, carry3}, y);
            chk("gap_model", out_f3, y);
            chk("gap_vld", out_valid3, 1);
            last = y;
        end

        // Order change mid-stream flushes and discards that sample.
        order_sel3 = 3'd2;
        carry3 = 3'b111;
        tick();
        chk("och_v", out_valid3, 0);
        chk("och_f", out_f3, 0);
        chk("och_s", settled3, 0);
        m_clear(0);
        carry3 = 3'b110;
        tick();
        m_step(0, 2, {1'b0, carry3}, y);
        chk("och_n1", out_f3, -1);
        chk("och_n1m", out_f3, y);
        chk("och_s1", settled3, 0);
        carry3 = 3'b100;
        tick();
        m_step(0, 2, {1'b0, carry3}, y);
        chk("och_n2", out_f3, 1);
        chk("och_s2", settled3, 1);

        carry3 = 3'b011;
        tick();
        m_step(0, 2, {1'b0, carry3}, y);
        chk("pre_clr", out_f3, y);
        clear3 = 1'b1;
        carry3 = 3'b111;
        tick();
        chk("clr_v", out_valid3, 0);
        chk("clr_f", out_f3, 0);
        chk("clr_s", settled3, 0);
        m_clear(0);
        clear3 = 1'b0;
        carry3 = 3'b010;
        tick();
        chk("clr_n1", out_f3, -1);
        carry3 = 3'b000;
        tick();
        chk("clr_n2", out_f3, 1);
        in_valid3 = 1'b0;

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        carry4 = 4'b0001;
        tick();
        chk("arst_pre", out_valid4, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_f", out_f4, 0);
        chk("arst_v", out_valid4, 0);
        chk("arst_s", settled4, 0);
        in_valid4 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
